// File: rtl/sync_frame_sequencer.sv
// sync_frame_sequencer
//   Starts one acquisition frame per accepted sync strobe: snapshots the way
//   meter and system timer, drives the probe transmit pulse, waits the dead
//   delay, opens the ADC acquisition gate, then offers a frame header over a
//   valid/ready handshake. Syncs arriving while a frame runs are counted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_enable              allows new frame starts
//   i_sync                single-cycle sync strobe
//   i_way_meter           way meter, snapshotted at frame start
//   i_system_timer        system timer, snapshotted at frame start
//   i_pulse_width         tx pulse length in cycles (0 = none)
//   i_acq_delay           dead delay between pulse and gate (0 = none)
//   i_acq_len             gate length in cycles (0 = none)
//   o_frame_start         one-cycle strobe in the first frame cycle
//   o_tx_pulse            probe transmit pulse
//   o_acq_gate            ADC acquisition window
//   o_busy                frame in progress
//   o_hdr_valid/i_hdr_ready  header handshake
//   o_hdr_frame/way/time  header fields
//   o_overrun_cntr        saturating count of rejected syncs
module sync_frame_sequencer #(
    parameter int PW_W  = 8,
    parameter int DLY_W = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic [31:0]      i_way_meter,
    input  logic [31:0]      i_system_timer,
    input  logic [PW_W-1:0]  i_pulse_width,
    input  logic [DLY_W-1:0] i_acq_delay,
    input  logic [LEN_W-1:0] i_acq_len,
    output logic             o_frame_start,
    output logic             o_tx_pulse,
    output logic             o_acq_gate,
    output logic             o_busy,
    output logic             o_hdr_valid,
    input  logic             i_hdr_ready,
    output logic [31:0]      o_hdr_frame,
    output logic [31:0]      o_hdr_way,
    output logic [31:0]      o_hdr_time,
    output logic [15:0]      o_overrun_cntr
);

    // One shared phase counter, wide enough for the largest phase field.
    localparam int CNT_W = (PW_W > DLY_W) ? ((PW_W > LEN_W) ? PW_W : LEN_W)
                                          : ((DLY_W > LEN_W) ? DLY_W : LEN_W);

    typedef enum logic [2:0] {IDLE, PULSE, DELAY, ACQ, HDR} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      frame_q, frame_d;
    logic [31:0]      way_q, way_d;
    logic [31:0]      time_q, time_d;
    logic [15:0]      ovr_q, ovr_d;
    logic             fs_q, fs_d;
    logic             start;

    assign start = (state_q == IDLE) && i_sync && i_enable;

    // cnt_q holds the number of cycles remaining in the current phase after
    // this one; zero-length phases are skipped by looking ahead at entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        len_d   = len_q;
        frame_d = frame_q;
        way_d   = way_q;
        time_d  = time_q;
        ovr_d   = ovr_q;
        fs_d    = 1'b0;

        if (i_sync && (state_q != IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    fs_d    = 1'b1;
                    frame_d = frame_q + 32'd1;
                    way_d   = i_way_meter;
                    time_d  = i_system_timer;
                    dly_d   = i_acq_delay;
                    len_d   = i_acq_len;
                    if (i_pulse_width != '0) begin
                        state_d = PULSE;
                        cnt_d   = CNT_W'(i_pulse_width) - CNT_W'(1);
                    end else if (i_acq_delay != '0) begin
                        state_d = DELAY;
                        cnt_d   = CNT_W'(i_acq_delay) - CNT_W'(1);
                    end else if (i_acq_len != '0) begin
                        state_d = ACQ;
                        cnt_d   = CNT_W'(i_acq_len) - CNT_W'(1);
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (dly_q != '0) begin
                    state_d = DELAY;
                    cnt_d   = CNT_W'(dly_q) - CNT_W'(1);
                end else if (len_q != '0) begin
                    state_d = ACQ;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    state_d = HDR;
                end
            end
            DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (len_q != '0) begin
                    state_d = ACQ;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    state_d = HDR;
                end
            end
            ACQ: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (i_hdr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            len_q   <= '0;
            frame_q <= '0;
            way_q   <= '0;
            time_q  <= '0;
            ovr_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            len_q   <= len_d;
            frame_q <= frame_d;
            way_q   <= way_d;
            time_q  <= time_d;
            ovr_q   <= ovr_d;
            fs_q    <= fs_d;
        end
    end

    assign o_frame_start  = fs_q;
    assign o_tx_pulse     = (state_q == PULSE);
    assign o_acq_gate     = (state_q == ACQ);
    assign o_hdr_valid    = (state_q == HDR);
    assign o_busy         = (state_q != IDLE);
    assign o_hdr_frame    = frame_q;
    assign o_hdr_way      = way_q;
    assign o_hdr_time     = time_q;
    assign o_overrun_cntr = ovr_q;

endmodule

// File: tb/tb_sync_frame_sequencer.sv
// tb_sync_frame_sequencer
//   Directed bench for sync_frame_sequencer. Accepted syncs push the expected
//   header (frame, way, time, handshake cycle) into a queue; a monitor checks
//   the offered header every valid cycle and pops it on the handshake.
module tb_sync_frame_sequencer;

    localparam int PW_W  = 8;
    localparam int DLY_W = 16;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_enable = 1'b0;
    logic             i_sync = 1'b0;
    logic [31:0]      i_way_meter = '0;
    logic [31:0]      i_system_timer = '0;
    logic [PW_W-1:0]  i_pulse_width = '0;
    logic [DLY_W-1:0] i_acq_delay = '0;
    logic [LEN_W-1:0] i_acq_len = '0;
    logic             i_hdr_ready = 1'b0;
    logic             o_frame_start, o_tx_pulse, o_acq_gate, o_busy, o_hdr_valid;
    logic [31:0]      o_hdr_frame, o_hdr_way, o_hdr_time;
    logic [15:0]      o_overrun_cntr;

    sync_frame_sequencer #(.PW_W(PW_W), .DLY_W(DLY_W), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_sync         (i_sync),
        .i_way_meter    (i_way_meter),
        .i_system_timer (i_system_timer),
        .i_pulse_width  (i_pulse_width),
        .i_acq_delay    (i_acq_delay),
        .i_acq_len      (i_acq_len),
        .o_frame_start  (o_frame_start),
        .o_tx_pulse     (o_tx_pulse),
        .o_acq_gate     (o_acq_gate),
        .o_busy         (o_busy),
        .o_hdr_valid    (o_hdr_valid),
        .i_hdr_ready    (i_hdr_ready),
        .o_hdr_frame    (o_hdr_frame),
        .o_hdr_way      (o_hdr_way),
        .o_hdr_time     (o_hdr_time),
        .o_overrun_cntr (o_overrun_cntr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_frame = '0;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] way;
        logic [31:0] tim;
        int          hs;
    } hdr_t;
    hdr_t sb[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && o_hdr_valid) begin
            if (sb.size() == 0) begin
                check("hdr_spurious", 64'(o_hdr_valid), 64'd0);
            end else begin
                check("hdr_frame", 64'(o_hdr_frame), 64'(sb[0].frame));
                check("hdr_way",   64'(o_hdr_way),   64'(sb[0].way));
                check("hdr_time",  64'(o_hdr_time),  64'(sb[0].tim));
                if (i_hdr_ready) begin
                    check("hdr_hs_cycle", 64'(cyc), 64'(sb[0].hs));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        i_pulse_width  = PW_W'($urandom);
        i_acq_delay    = DLY_W'($urandom);
        i_acq_len      = LEN_W'($urandom);
        i_way_meter    = $urandom;
        i_system_timer = $urandom;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        i_sync      = 1'b0;
        i_enable    = 1'b0;
        i_hdr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 64'({o_frame_start, o_tx_pulse, o_acq_gate, o_busy, o_hdr_valid}), 64'd0);
        check("rst_frame", 64'(o_hdr_frame), 64'd0);
        check("rst_way", 64'(o_hdr_way), 64'd0);
        check("rst_time", 64'(o_hdr_time), 64'd0);
        check("rst_ovr", 64'(o_overrun_cntr), 64'd0);
        check("sb_empty_at_reset", 64'(sb.size()), 64'd0);
        sb.delete();
        exp_frame = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives a sync in the next cycle (cycle T); s = cycles ready is held low in HDR.
    task automatic start_frame(int w, int d, int l, int s, bit push);
        hdr_t e;
        next_cycle();
        i_enable       = 1'b1;
        i_sync         = 1'b1;
        i_hdr_ready    = 1'b1;
        i_pulse_width  = PW_W'(w);
        i_acq_delay    = DLY_W'(d);
        i_acq_len      = LEN_W'(l);
        i_way_meter    = $urandom;
        i_system_timer = $urandom;
        if (push) begin
            exp_frame++;
            e.frame = exp_frame;
            e.way   = i_way_meter;
            e.tim   = i_system_timer;
            e.hs    = cyc + 1 + w + d + l + s;
            sb.push_back(e);
        end
    endtask

    // Checks the control outputs for cycles T+1..T+H+s+1; optional extra sync at T+xk.
    task automatic watch(int w, int d, int l, int s, int xk);
        int         h;
        logic [4:0] e_vec;
        h = 1 + w + d + l;
        for (int k = 1; k <= h + s + 1; k++) begin
            next_cycle();
            i_sync      = (k == xk);
            i_hdr_ready = (k < h) || (k >= h + s);
            i_enable    = (k <= h + s) ? 1'($urandom_range(0, 1)) : 1'b1;
            scramble();
            @(negedge clk);
            e_vec = {k == 1, k <= w, (k > w + d) && (k <= w + d + l),
                     k <= h + s, (k >= h) && (k <= h + s)};
            check($sformatf("wave_k%0d", k),
                  64'({o_frame_start, o_tx_pulse, o_acq_gate, o_busy, o_hdr_valid}),
                  64'(e_vec));
        end
    endtask

    initial begin
        do_reset();

        // Nominal frame, then all phases zero, then a long header stall.
        start_frame(4, 10, 20, 0, 1'b1);
        watch(4, 10, 20, 0, 0);
        start_frame(0, 0, 0, 0, 1'b1);
        watch(0, 0, 0, 0, 0);
        start_frame(2, 0, 3, 50, 1'b1);
        watch(2, 0, 3, 50, 0);
        check("ovr_none", 64'(o_overrun_cntr), 64'd0);

        // Overrun: syncs at 0, 5 and 40 with a 38-cycle frame.
        do_reset();
        start_frame(4, 10, 23, 0, 1'b1);
        watch(4, 10, 23, 0, 5);
        check("ovr_one", 64'(o_overrun_cntr), 64'd1);
        start_frame(4, 10, 23, 0, 1'b1);
        watch(4, 10, 23, 0, 0);
        check("ovr_still_one", 64'(o_overrun_cntr), 64'd1);
        check("frame_count", 64'(o_hdr_frame), 64'd2);

        // Disabled syncs are ignored, then saturation during a stalled header.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            i_enable = 1'b0;
            i_sync   = 1'b1;
            next_cycle();
            i_sync = 1'b0;
            @(negedge clk);
            check("dis_idle", 64'({o_frame_start, o_busy}), 64'd0);
        end
        check("dis_ovr", 64'(o_overrun_cntr), 64'd0);
        start_frame(1, 1, 1, 70000, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            i_sync = 1'b0;
            scramble();
        end
        next_cycle();
        i_hdr_ready = 1'b0;
        i_sync      = 1'b1;
        @(negedge clk);
        check("sat_hdr_valid", 64'(o_hdr_valid), 64'd1);
        for (int j = 1; j < 70000; j++) begin
            next_cycle();
            if (j == 1) begin
                @(negedge clk);
                check("sat_ovr_first", 64'(o_overrun_cntr), 64'd1);
            end
        end
        next_cycle();
        i_sync      = 1'b0;
        i_hdr_ready = 1'b1;
        @(negedge clk);
        check("sat_ovr_ffff", 64'(o_overrun_cntr), 64'hFFFF);
        next_cycle();
        @(negedge clk);
        check("sat_idle", 64'(o_busy), 64'd0);

        // Reset in ACQ aborts the frame; counter restarts at 1.
        start_frame(2, 2, 10, 0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            i_sync = 1'b0;
            @(negedge clk);
        end
        check("acq_gate_open", 64'(o_acq_gate), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_abort", 64'({o_tx_pulse, o_acq_gate, o_hdr_valid, o_busy}), 64'd0);
        do_reset();
        start_frame(0, 0, 0, 0, 1'b1);
        watch(0, 0, 0, 0, 0);

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_frame_sequencer.md
Name: sync_frame_sequencer

Overview:
- Downstream consumer of the synchronizer's o_sync strobe.
- Each accepted sync starts one acquisition frame: snapshot of way meter and system timer, probe transmit pulse, programmable dead delay, then ADC acquisition gate.
- After the gate closes, a frame header (frame number, way, time) is offered to the packet builder over a valid/ready handshake.
- Syncs that arrive while a frame is in progress are rejected and counted.

Parameters:
- PW_W, 8, width of the transmit pulse width field (clk cycles).
- DLY_W, 16, width of the acquisition delay field (clk cycles).
- LEN_W, 16, width of the acquisition length field (clk cycles).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  enables frame starts; a running frame always completes.
- i_sync  in  1  single-cycle sync strobe from synchronizer.
- i_way_meter  in  32  way meter value, snapshotted at frame start.
- i_system_timer  in  32  microsecond timer, snapshotted at frame start.
- i_pulse_width  in  PW_W  tx pulse length in cycles; 0 = no pulse.
- i_acq_delay  in  DLY_W  cycles between tx pulse end and gate open; 0 = none.
- i_acq_len  in  LEN_W  gate length in cycles; 0 = no gate.
- o_frame_start  out  1  one-cycle strobe in the first frame cycle.
- o_tx_pulse  out  1  probe transmit pulse.
- o_acq_gate  out  1  ADC acquisition window.
- o_busy  out  1  high whenever state != IDLE.
- o_hdr_valid  out  1  header available.
- i_hdr_ready  in  1  header consumer ready.
- o_hdr_frame  out  32  frame number of the offered header.
- o_hdr_way  out  32  snapshotted way meter.
- o_hdr_time  out  32  snapshotted system timer.
- o_overrun_cntr  out  16  rejected-sync count, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; frame counter, snapshots and overrun counter 0. Reset mid-frame aborts immediately: tx and gate drop asynchronously, no header is issued.
- States: IDLE, PULSE, DELAY, ACQ, HDR. Outputs decode from registered state:
  - o_tx_pulse = PULSE
  - o_acq_gate = ACQ
  - o_hdr_valid = HDR
  - o_busy = state != IDLE
- Frame start: i_sync high at cycle T with state IDLE and i_enable high.
  - At the T edge, latch i_pulse_width, i_acq_delay, i_acq_len, i_way_meter and i_system_timer.
  - Increment the frame counter (32-bit, wraps FFFFFFFF -> 0). The new value becomes o_hdr_frame; the first frame is 1.
  - o_frame_start is high in cycle T+1 only.
- Timing, using latched values W, D, L:
  - PULSE occupies cycles T+1..T+W.
  - DELAY occupies the next D cycles.
  - ACQ occupies the next L cycles.
  - HDR starts at T+1+W+D+L.
  - Any zero-length phase is skipped with no idle cycle, so W=D=L=0 gives HDR at T+1.
- Inputs changed mid-frame have no effect on the running frame.
- HDR: o_hdr_valid holds until i_hdr_ready is sampled high. The header fields are stable while valid is high. On the handshake cycle the state returns to IDLE at the next edge.
- Overrun: i_sync high while state != IDLE (including the HDR handshake cycle) increments o_overrun_cntr, saturating at FFFF. That sync is otherwise ignored.
- i_sync while IDLE and i_enable low is ignored and not counted.
- Deasserting i_enable mid-frame has no effect on the current frame.
- The earliest next frame start is the cycle after the state returns to IDLE.

Test Plan:
- W=4, D=10, L=20, ready held high, sync at cycle 0 -> frame_start at 1; tx at cycles 1..4; gate at 15..34; hdr_valid at 35 only; busy at 1..35; hdr_frame=1.
- W=0, D=0, L=0, sync -> no tx and no gate; hdr_valid at cycle 1; way and time equal the values present at the sync cycle.
- W=2, D=0, L=3, ready low for 50 cycles after valid -> valid and fields stable for 50 cycles; IDLE the cycle after ready is sampled high.
- Syncs at cycles 0, 5 and 40 with frame length 38 -> syncs 0 and 40 start frames 1 and 2; sync 5 gives overrun_cntr=1; frame counter is 2.
- i_enable low plus 3 syncs -> no activity, overrun stays 0; then enable high, sync during HDR with ready low -> overrun increments, and 70000 such syncs saturate it at FFFF.
- rst_n low during ACQ -> tx, gate and valid go 0 immediately; after release a fresh sync yields hdr_frame=1.
